gpio_in_irq: RTL



---
 rtl/gpio_in_irq_if.sv | 24 ++
 rtl/gpio_in_irq.sv | 102 ++++++++++
 2 files changed

// File: rtl/gpio_in_irq_if.sv
// Pin, configuration and status bundle between the GPIO register block (master)
// and the input-conditioning / interrupt stage (slave).
interface gpio_in_irq_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] portin;
  logic [WIDTH-1:0] inten;
  logic [WIDTH-1:0] inttype;
  logic [WIDTH-1:0] intpol;
  logic [WIDTH-1:0] intclr;
  logic [WIDTH-1:0] portin_sync;
  logic [WIDTH-1:0] gpioint;
  logic             combint;

  modport master (
    output portin, inten, inttype, intpol, intclr,
    input  portin_sync, gpioint, combint
  );

  modport slave (
    input  portin, inten, inttype, intpol, intclr,
    output portin_sync, gpioint, combint
  );
endinterface

// File: rtl/gpio_in_irq.sv
// GPIO input conditioning: synchronizer, optional debounce, edge/level interrupt status.
// Define GPIO_IN_IRQ_DEBOUNCE_EN to build the per-pin debounce filter.
module gpio_in_irq #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 8
) (
  input  logic          clk,
  input  logic          rst,
  gpio_in_irq_if.slave  io_gpio
);

  localparam int ARM_MAX = SYNC_STAGES + 1;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_s_sync;
  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge_ev;
  logic [WIDTH-1:0] w_level_ev;
  logic [WIDTH-1:0] w_ev;
  logic [WIDTH-1:0] r_status;
  logic [WIDTH-1:0] w_status_nxt;
  logic [2:0]       r_arm_cnt;
  logic             w_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= io_gpio.portin;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_IN_IRQ_DEBOUNCE_EN
  logic [WIDTH-1:0] r_filt;
  logic [7:0]       r_db_cnt [WIDTH];

  // A pin's filtered value only follows s_sync after DB_CYCLES consecutive mismatches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt <= '0;
      for (int i = 0; i < WIDTH; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_s_sync[i] != r_filt[i]) begin
          if (r_db_cnt[i] == 8'(DB_CYCLES - 1)) begin
            r_filt[i]   <= w_s_sync[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 8'd1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = w_s_sync;
`endif

  // Edges are ignored until the synchronizer has flushed its reset zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= '0;
      r_arm_cnt <= '0;
    end else begin
      r_prev <= w_filt;
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 3'd1;
    end
  end

  assign w_armed    = (r_arm_cnt == 3'(ARM_MAX));
  assign w_rise     = w_filt & ~r_prev;
  assign w_fall     = ~w_filt & r_prev;
  assign w_edge_ev  = ((io_gpio.intpol & w_rise) | (~io_gpio.intpol & w_fall)) & {WIDTH{w_armed}};
  assign w_level_ev = ~(io_gpio.intpol ^ w_filt);
  assign w_ev       = (io_gpio.inttype & w_edge_ev) | (~io_gpio.inttype & w_level_ev);

  // Edge status is sticky with set winning over clear; level status just tracks the event.
  assign w_status_nxt = io_gpio.inten &
                        ((io_gpio.inttype & (w_ev | (r_status & ~io_gpio.intclr))) |
                         (~io_gpio.inttype & w_ev));

  always_ff @(posedge clk) begin
    if (rst) r_status <= '0;
    else     r_status <= w_status_nxt;
  end

  assign io_gpio.portin_sync = w_filt;
  assign io_gpio.gpioint     = r_status;
  assign io_gpio.combint     = |r_status;

endmodule
